trig_pulse_shaper: RTL
======================

# trig_pulse_shaper

Conditions the trace trigger produced by `trace_top` (`O_trace_trig_out`) before it reaches the `trig_out`/`mcx_trig` pins. On each rising edge of the incoming trigger it emits a programmable burst: an optional delay, then 1..N pulses of programmable width and gap, then a holdoff window. Triggers that arrive while a burst or holdoff is in progress are counted as missed. It runs in the `fe_clk` domain, and its configuration comes from `trace_top` registers.

## Interface
- `pCNT_WIDTH`, 16: width of the delay, width, gap and holdoff counts.
- `pNUM_WIDTH`, 8: width of the pulse-count field.
- `fe_clk`  in  1  front-end clock; the only clock.
- `fpga_reset_n`  in  1  reset, asynchronous, active-low.
- `I_trig`  in  1  trigger level from `trace_top`; synchronous to `fe_clk`.
- `I_enable`  in  1  block enable; low aborts any activity.
- `I_delay`  in  pCNT_WIDTH  cycles from edge detection to the first pulse.
- `I_width`  in  pCNT_WIDTH  pulse high time in cycles; 0 is treated as 1.
- `I_gap`  in  pCNT_WIDTH  low time between pulses; 0 is treated as 1.
- `I_num`  in  pNUM_WIDTH  pulses per burst; 0 is treated as 1.
- `I_holdoff`  in  pCNT_WIDTH  dead cycles after the last pulse; 0 is allowed.
- `I_missed_clr`  in  1  synchronous clear of `O_missed`.
- `O_trig_out`  out  1  shaped trigger, registered.
- `O_busy`  out  1  high whenever the state is not IDLE.
- `O_missed`  out  8  saturating count of ignored trigger edges.

## Operation
- **Edge detect:** `edge = I_trig & ~trig_prev`. `trig_prev` is registered every cycle and resets to 1, so a trigger that is already high when reset releases is not an edge.
- **Config latch:** all configuration inputs are latched when an edge is accepted in IDLE. Changes during a burst have no effect until the next burst.
- **States:**
  - IDLE: on `edge & I_enable`, go to DELAY if latched delay > 0, otherwise to PULSE.
  - DELAY: count down the delay, then go to PULSE.
  - PULSE: drive the output high for W cycles. Then go to GAP if pulses remain, else to HOLD if holdoff > 0, else to IDLE.
  - GAP: output low for G cycles, then go to PULSE.
  - HOLD: output low for H cycles, then go to IDLE.
- **Counters:** one down-counter for phase length and one pulse counter. Zero-substitution (0 → 1) is applied at the latch.
- **Missed triggers:** an edge seen in any state other than IDLE increments `O_missed`, which saturates at 255. An edge with `I_enable` low is ignored and not counted.
- **Simultaneous events:**
  - An edge in the cycle that returns to IDLE is a miss; it does not start a burst.
  - `I_missed_clr` and a miss in the same cycle: clear wins, and `O_missed` becomes 0.
- **Abort:** `I_enable` low in any state sends the block to IDLE on the next edge. `O_trig_out` and `O_busy` go to 0 at that edge and the counters are zeroed.
- **Reset:** asserting `fpga_reset_n` low at any time, including mid-pulse, immediately forces state IDLE, `O_trig_out`=0, `O_busy`=0 and `O_missed`=0.

## Timing
- `I_trig` goes high after clock edge k−1 and the edge is detected at edge k. `O_trig_out` rises at edge k+D. Latency from the `I_trig` rise is D+1 cycles.
- Each pulse is high for exactly W cycles; consecutive pulses are separated by exactly G low cycles.
- `O_busy` is high from edge k through the end of holdoff. It is high for D + N·W + (N−1)·G + H cycles in total, where D, W, G, N, H are the effective latched values.
- The earliest accepted retrigger is the first edge after `O_busy` falls.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- State encodings (IDLE, DELAY, PULSE, GAP, HOLD) go in `defines_trace.v` as `TPS_*` constants, next to the other trace defines.
- The block is a single module with no sub-modules; one shared down-counter serves all phases.
- `trace_top` instantiates it between `O_trace_trig_out` and the top-level `trig_out`. Its configuration registers get new addresses under `TRACE_REG_SELECT`.

## Test plan
- **Single pulse:** D=3, W=2, N=1, H=0; pulse `I_trig` high. Expect `O_trig_out` high exactly at cycles 4–5 after the `I_trig` rise, and `O_busy` high for 5 cycles.
- **Burst:** D=0, W=2, G=1, N=3. Expect the output pattern 1,1,0,1,1,0,1,1 starting 1 cycle after the rise, then 0.
- **Retrigger during busy:** N=1, W=10, H=20; give 3 extra edges during the pulse/holdoff. Expect exactly one pulse and `O_missed`=3. Follow with 300 extra edges: `O_missed` sticks at 255. Assert `I_missed_clr`: `O_missed` reads 0.
- **Zero config:** W=0, G=0, N=0, D=0. Expect one 1-cycle pulse, 1 cycle after the rise.
- **Abort:** drop `I_enable` in the 2nd cycle of a W=8 pulse. Expect `O_trig_out`=0 and `O_busy`=0 at the next edge, and no further pulses.
- **Reset:** assert `fpga_reset_n`=0 mid-pulse. Expect all outputs 0 with no clock edge required. Hold `I_trig`=1 through reset release: no burst starts.

Source files
------------

// File: rtl/trig_pulse_shaper_pkg.sv
// rtl/trig_pulse_shaper_pkg.sv - shared types and helpers for the trigger pulse shaper
//
// Purpose: state encodings for the burst sequencer (the TPS_* constants that
// sit next to the other trace defines) and the saturating miss-count helper.

package trig_pulse_shaper_pkg;

    typedef enum logic [2:0] {
        TPS_IDLE  = 3'd0,
        TPS_DELAY = 3'd1,
        TPS_PULSE = 3'd2,
        TPS_GAP   = 3'd3,
        TPS_HOLD  = 3'd4
    } tps_state_t;

    localparam logic [7:0] MISSED_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == MISSED_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/trig_pulse_shaper.sv
// rtl/trig_pulse_shaper.sv - shapes the trace trigger into a delayed pulse burst with holdoff
//
// Purpose: on each accepted rising edge of I_trig emit an optional delay, then
// 1..N pulses of programmable width and gap, then a holdoff window. Edges seen
// while a burst or holdoff is running are counted as missed.
//
// Ports:
//   fe_clk        front-end clock
//   fpga_reset_n  asynchronous active-low reset
//   I_trig        trigger level, synchronous to fe_clk
//   I_enable      block enable; low aborts any activity
//   I_delay       cycles from edge detection to the first pulse
//   I_width       pulse high time (0 treated as 1)
//   I_gap         low time between pulses (0 treated as 1)
//   I_num         pulses per burst (0 treated as 1)
//   I_holdoff     dead cycles after the last pulse (0 allowed)
//   I_missed_clr  synchronous clear of O_missed
//   O_trig_out    shaped trigger, registered
//   O_busy        high whenever the sequencer is not idle, registered
//   O_missed      saturating count of ignored trigger edges

module trig_pulse_shaper
    import trig_pulse_shaper_pkg::*;
#(
    parameter int pCNT_WIDTH = 16,
    parameter int pNUM_WIDTH = 8
) (
    input  logic                  fe_clk,
    input  logic                  fpga_reset_n,
    input  logic                  I_trig,
    input  logic                  I_enable,
    input  logic [pCNT_WIDTH-1:0] I_delay,
    input  logic [pCNT_WIDTH-1:0] I_width,
    input  logic [pCNT_WIDTH-1:0] I_gap,
    input  logic [pNUM_WIDTH-1:0] I_num,
    input  logic [pCNT_WIDTH-1:0] I_holdoff,
    input  logic                  I_missed_clr,
    output logic                  O_trig_out,
    output logic                  O_busy,
    output logic [7:0]            O_missed
);

    localparam logic [pCNT_WIDTH-1:0] CNT_ONE = pCNT_WIDTH'(1);
    localparam logic [pNUM_WIDTH-1:0] NUM_ONE = pNUM_WIDTH'(1);

    tps_state_t            state, state_nx;
    logic [pCNT_WIDTH-1:0] cnt, cnt_nx;
    logic [pCNT_WIDTH-1:0] width_l, width_nx;
    logic [pCNT_WIDTH-1:0] gap_l, gap_nx;
    logic [pCNT_WIDTH-1:0] hold_l, hold_nx;
    logic [pNUM_WIDTH-1:0] pulses, pulses_nx;
    logic                  trig_prev;
    logic                  trig_edge;
    logic                  miss;

    logic [pCNT_WIDTH-1:0] width_eff, gap_eff;
    logic [pNUM_WIDTH-1:0] num_eff;

    assign trig_edge = I_trig & ~trig_prev;
    assign miss      = trig_edge & I_enable & (state != TPS_IDLE);

    // Zero-substitution happens here so the latched values are always >= 1.
    assign width_eff = (I_width == '0) ? CNT_ONE : I_width;
    assign gap_eff   = (I_gap   == '0) ? CNT_ONE : I_gap;
    assign num_eff   = (I_num   == '0) ? NUM_ONE : I_num;

    // The shared down-counter holds "cycles remaining in this phase minus one",
    // so a phase ends in the cycle where it reads zero.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        width_nx  = width_l;
        gap_nx    = gap_l;
        hold_nx   = hold_l;
        pulses_nx = pulses;

        case (state)
            TPS_IDLE: begin
                if (trig_edge && I_enable) begin
                    width_nx  = width_eff;
                    gap_nx    = gap_eff;
                    hold_nx   = I_holdoff;
                    pulses_nx = num_eff;
                    if (I_delay != '0) begin
                        state_nx = TPS_DELAY;
                        cnt_nx   = I_delay - CNT_ONE;
                    end else begin
                        state_nx = TPS_PULSE;
                        cnt_nx   = width_eff - CNT_ONE;
                    end
                end
            end
            TPS_DELAY: begin
                if (cnt == '0) begin
                    state_nx = TPS_PULSE;
                    cnt_nx   = width_l - CNT_ONE;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            TPS_PULSE: begin
                if (cnt == '0) begin
                    if (pulses > NUM_ONE) begin
                        state_nx  = TPS_GAP;
                        cnt_nx    = gap_l - CNT_ONE;
                        pulses_nx = pulses - NUM_ONE;
                    end else if (hold_l != '0) begin
                        state_nx = TPS_HOLD;
                        cnt_nx   = hold_l - CNT_ONE;
                    end else begin
                        state_nx  = TPS_IDLE;
                        pulses_nx = '0;
                    end
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            TPS_GAP: begin
                if (cnt == '0) begin
                    state_nx = TPS_PULSE;
                    cnt_nx   = width_l - CNT_ONE;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            TPS_HOLD: begin
                if (cnt == '0) begin
                    state_nx  = TPS_IDLE;
                    pulses_nx = '0;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nx = TPS_IDLE;
            end
        endcase

        // Enable low overrides everything, including a fresh edge in IDLE.
        if (!I_enable) begin
            state_nx  = TPS_IDLE;
            cnt_nx    = '0;
            pulses_nx = '0;
        end
    end

    always_ff @(posedge fe_clk or negedge fpga_reset_n) begin
        if (!fpga_reset_n) begin
            state      <= TPS_IDLE;
            cnt        <= '0;
            width_l    <= '0;
            gap_l      <= '0;
            hold_l     <= '0;
            pulses     <= '0;
            trig_prev  <= 1'b1;   // a level already high at reset release is not an edge
            O_trig_out <= 1'b0;
            O_busy     <= 1'b0;
            O_missed   <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            width_l    <= width_nx;
            gap_l      <= gap_nx;
            hold_l     <= hold_nx;
            pulses     <= pulses_nx;
            trig_prev  <= I_trig;
            // Outputs are registered from the next state so they track the state register exactly.
            O_trig_out <= (state_nx == TPS_PULSE);
            O_busy     <= (state_nx != TPS_IDLE);
            if (I_missed_clr) begin
                O_missed <= '0;
            end else if (miss) begin
                O_missed <= sat_inc8(O_missed);
            end
        end
    end

endmodule
